// File: rtl/doodle_pkg.sv
// doodle_pkg: shared types and constants for the Doodle physics block.
//   KEY_*         : keyboard keycodes for left / right / jump
//   phys_state_t  : motion state machine encoding
//   coord_t       : 10-bit screen coordinate
//   speed_t       : signed 8-bit vertical speed (negative = upward)
package doodle_pkg;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_JUMP  = 8'h2C;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RESPAWN = 2'd1,
        DEAD    = 2'd2
    } phys_state_t;

    typedef logic [9:0]        coord_t;
    typedef logic signed [7:0] speed_t;

endpackage

// File: rtl/doodle_physics_plat_hit_detect.sv
// plat_hit_detect: combinational landing test of the Doodle against N_PLAT
// platform slots, lowest matching slot wins.
//   x_new      : Doodle X after this frame's horizontal move
//   y          : Doodle Y before this frame's vertical move
//   v          : vertical speed before this frame's update
//   plat_*     : per-slot platform position / valid / spring enable
//   hit        : some slot matched
//   idx        : lowest matching slot
//   spring     : that slot's spring zone was touched
module plat_hit_detect
    import doodle_pkg::*;
#(
    parameter int N_PLAT   = 8,
    parameter int PLAT_W   = 60,
    parameter int SPRING_W = 5,
    parameter int SIZE     = 32,
    parameter int IDX_W    = 3
) (
    input  coord_t                   x_new,
    input  coord_t                   y,
    input  speed_t                   v,
    input  logic [N_PLAT-1:0][9:0]   plat_x,
    input  logic [N_PLAT-1:0][9:0]   plat_y,
    input  logic [N_PLAT-1:0]        plat_valid,
    input  logic [N_PLAT-1:0]        spring_en,
    output logic                     hit,
    output logic [IDX_W-1:0]         idx,
    output logic                     spring
);

    logic              v_pos;
    logic [11:0]       xn;
    logic [11:0]       yb;
    logic [11:0]       vu;
    logic [N_PLAT-1:0] match;
    logic [N_PLAT-1:0] spr;

    // Only falling sprites land; once v is known positive it can be
    // zero-extended and all comparisons stay unsigned.
    assign v_pos = (v > speed_t'(0));
    assign xn    = {2'b00, x_new};
    assign yb    = {2'b00, y} + 12'(SIZE);
    assign vu    = {4'b0000, v};

    for (genvar i = 0; i < N_PLAT; i++) begin : g_slot
        logic [11:0] px;
        logic [11:0] py;
        assign px       = {2'b00, plat_x[i]};
        assign py       = {2'b00, plat_y[i]};
        assign match[i] = plat_valid[i] && v_pos
                          && (xn < px + 12'(PLAT_W))
                          && (xn + 12'(SIZE) > px)
                          && (yb <= py)
                          && (yb + vu >= py);
        assign spr[i]   = spring_en[i]
                          && (xn + 12'(SIZE) > px + 12'(PLAT_W - SPRING_W));
    end

    // Scan from the top so the lowest matching slot is written last.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        spring = 1'b0;
        for (int i = N_PLAT - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit    = 1'b1;
                idx    = IDX_W'(i);
                spring = spr[i];
            end
        end
    end

endmodule

// File: rtl/doodle_physics.sv
// doodle_physics: per-frame Doodle kinematics (horizontal wrap, gravity,
// jump with cooldown), platform/spring landing, fall-out respawn, health.
//   Clk, Reset          : clock, synchronous active-high reset
//   frame_tick, run     : state advances only when both are high
//   keycode             : left / right / jump key
//   plat_x/y/valid, spring_en : platform slots from the generator
//   doodle_x/y, y_speed : sprite position and vertical speed
//   health, dead        : remaining lives, health exhausted
//   land_pulse/idx/spring : one-cycle landing event and its details
module doodle_physics
    import doodle_pkg::*;
#(
    parameter int N_PLAT      = 8,
    parameter int PLAT_W      = 60,
    parameter int SPRING_W    = 5,
    parameter int SIZE        = 32,
    parameter int X_MIN       = 140,
    parameter int X_MAX       = 499,
    parameter int Y_TOP       = 11,
    parameter int Y_MAX       = 478,
    parameter int X_STEP      = 3,
    parameter int GRAVITY     = 1,
    parameter int V_TERM      = 4,
    parameter int V_JUMP      = -6,
    parameter int V_BOUNCE    = -12,
    parameter int V_SPRING    = -18,
    parameter int JUMP_CD     = 18,
    parameter int HEALTH_INIT = 10,
    parameter int START_X     = 304,
    parameter int START_Y     = 320,
    parameter int IDX_W       = (N_PLAT > 1) ? $clog2(N_PLAT) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_tick,
    input  logic                   run,
    input  logic [7:0]             keycode,
    input  logic [N_PLAT-1:0][9:0] plat_x,
    input  logic [N_PLAT-1:0][9:0] plat_y,
    input  logic [N_PLAT-1:0]      plat_valid,
    input  logic [N_PLAT-1:0]      spring_en,
    output coord_t                 doodle_x,
    output coord_t                 doodle_y,
    output speed_t                 y_speed,
    output logic [3:0]             health,
    output logic                   land_pulse,
    output logic [IDX_W-1:0]       land_idx,
    output logic                   land_spring,
    output logic                   dead
);

    localparam int CD_W = $clog2(JUMP_CD + 1);
    localparam logic signed [10:0] X_HI = 11'(X_MAX - SIZE);
    localparam logic signed [10:0] X_LO = 11'(X_MIN);
    localparam logic signed [11:0] Y_LO = 12'(Y_TOP);

    phys_state_t      state_q, state_d;
    coord_t           x_q, x_d, y_q, y_d;
    speed_t           v_q, v_d;
    logic [3:0]       health_q, health_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic             land_pulse_q, land_pulse_d;
    logic [IDX_W-1:0] land_idx_q, land_idx_d;
    logic             land_spring_q, land_spring_d;

    logic signed [10:0] vx, x_sum;
    logic signed [11:0] y_sum;
    coord_t             x_new, y_new;
    logic               fall_out;
    logic               hit, hit_spring;
    logic [IDX_W-1:0]   hit_idx;

    // Candidate motion for this frame, evaluated in signed widths wide
    // enough that a left step from X_MIN or an upward step near Y_TOP
    // cannot wrap through zero.
    always_comb begin
        vx = '0;
        if (keycode == KEY_LEFT)       vx = -11'(X_STEP);
        else if (keycode == KEY_RIGHT) vx = 11'(X_STEP);
        x_sum = $signed({1'b0, x_q}) + vx;
        if (x_sum > X_HI)      x_new = coord_t'(X_MAX - SIZE) == 0 ? '0 : coord_t'(X_MIN);
        else if (x_sum < X_LO) x_new = coord_t'(X_MAX - SIZE);
        else                   x_new = x_sum[9:0];
        y_sum = $signed({2'b00, y_q}) + 12'(v_q);
        y_new = (y_sum < Y_LO) ? coord_t'(Y_TOP) : y_sum[9:0];
    end

    assign fall_out = (y_q > coord_t'(Y_MAX - SIZE));

    plat_hit_detect #(
        .N_PLAT   (N_PLAT),
        .PLAT_W   (PLAT_W),
        .SPRING_W (SPRING_W),
        .SIZE     (SIZE),
        .IDX_W    (IDX_W)
    ) u_hit (
        .x_new      (x_new),
        .y          (y_q),
        .v          (v_q),
        .plat_x     (plat_x),
        .plat_y     (plat_y),
        .plat_valid (plat_valid),
        .spring_en  (spring_en),
        .hit        (hit),
        .idx        (hit_idx),
        .spring     (hit_spring)
    );

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        v_d           = v_q;
        health_d      = health_q;
        cd_d          = cd_q;
        land_pulse_d  = 1'b0;
        land_idx_d    = land_idx_q;
        land_spring_d = land_spring_q;
        if (frame_tick && run) begin
            unique case (state_q)
                RUN: begin
                    if (fall_out) begin
                        // Position is left where it fell; RESPAWN relocates it.
                        health_d = (health_q == 4'd0) ? 4'd0 : health_q - 4'd1;
                        state_d  = (health_d == 4'd0) ? DEAD : RESPAWN;
                    end else begin
                        x_d = x_new;
                        y_d = y_new;
                        if (keycode == KEY_JUMP && cd_q == '0) begin
                            v_d  = speed_t'(V_JUMP);
                            cd_d = CD_W'(JUMP_CD);
                        end else if (cd_q != '0) begin
                            cd_d = cd_q - CD_W'(1);
                        end
                        if (v_d < speed_t'(V_TERM)) v_d = v_d + speed_t'(GRAVITY);
                        // A landing overrides both the jump and gravity.
                        if (hit) begin
                            v_d           = hit_spring ? speed_t'(V_SPRING) : speed_t'(V_BOUNCE);
                            cd_d          = CD_W'(1);
                            land_pulse_d  = 1'b1;
                            land_idx_d    = hit_idx;
                            land_spring_d = hit_spring;
                        end
                    end
                end
                RESPAWN: begin
                    x_d     = coord_t'(START_X);
                    y_d     = coord_t'(Y_TOP);
                    v_d     = '0;
                    state_d = RUN;
                end
                DEAD: ;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= RUN;
            x_q           <= coord_t'(START_X);
            y_q           <= coord_t'(START_Y);
            v_q           <= speed_t'(V_JUMP);
            health_q      <= 4'(HEALTH_INIT);
            cd_q          <= '0;
            land_pulse_q  <= 1'b0;
            land_idx_q    <= '0;
            land_spring_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            v_q           <= v_d;
            health_q      <= health_d;
            cd_q          <= cd_d;
            land_pulse_q  <= land_pulse_d;
            land_idx_q    <= land_idx_d;
            land_spring_q <= land_spring_d;
        end
    end

    assign doodle_x    = x_q;
    assign doodle_y    = y_q;
    assign y_speed     = v_q;
    assign health      = health_q;
    assign land_pulse  = land_pulse_q;
    assign land_idx    = land_idx_q;
    assign land_spring = land_spring_q;
    assign dead        = (state_q == DEAD);

endmodule

// File: tb/tb_doodle_physics.sv
module tb_doodle_physics;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic            frame_tick = 1'b0;
    logic            run = 1'b1;
    logic [7:0]      keycode = 8'h00;
    logic [7:0][9:0] plat_x = '0;
    logic [7:0][9:0] plat_y = '0;
    logic [7:0]      plat_valid = '0;
    logic [7:0]      spring_en = '0;
    logic [9:0]      doodle_x, doodle_y;
    logic [7:0]      y_speed;
    logic [3:0]      health;
    logic            land_pulse, land_spring, dead;
    logic [2:0]      land_idx;

    doodle_physics dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .run(run),
        .keycode(keycode), .plat_x(plat_x), .plat_y(plat_y),
        .plat_valid(plat_valid), .spring_en(spring_en),
        .doodle_x(doodle_x), .doodle_y(doodle_y), .y_speed(y_speed),
        .health(health), .land_pulse(land_pulse), .land_idx(land_idx),
        .land_spring(land_spring), .dead(dead)
    );

    always #5 Clk = ~Clk;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    // Reference model: game rules in plain integers. mst: 0 play, 1 respawn, 2 dead.
    int mx, my, mv, mh, mcd, mst;
    int e_pulse, e_idx, e_spr;

    task automatic model_step();
        int xn, yn, vn, px, py, found;
        e_pulse = 0;
        if (Reset) begin
            mx = 304; my = 320; mv = -6; mh = 10; mcd = 0; mst = 0;
            e_idx = 0; e_spr = 0;
            return;
        end
        if (!(frame_tick && run)) return;
        if (mst == 2) return;
        if (mst == 1) begin
            mx = 304; my = 11; mv = 0; mst = 0;
            return;
        end
        if (my > 478 - 32) begin
            if (mh > 0) mh = mh - 1;
            mst = (mh == 0) ? 2 : 1;
            return;
        end
        xn = mx + ((keycode == 8'h04) ? -3 : (keycode == 8'h07) ? 3 : 0);
        if (xn > 467) xn = 140;
        else if (xn < 140) xn = 467;
        yn = my + mv;
        if (yn < 11) yn = 11;
        vn = mv;
        if (keycode == 8'h2C && mcd == 0) begin vn = -6; mcd = 18; end
        else if (mcd > 0) mcd = mcd - 1;
        if (vn < 4) vn = vn + 1;
        found = 0;
        for (int i = 0; i < 8; i++) begin
            px = int'(plat_x[i]);
            py = int'(plat_y[i]);
            if (found == 0 && plat_valid[i] && mv > 0 && xn < px + 60 && xn + 32 > px
                && my + 32 <= py && my + 32 + mv >= py) begin
                found = 1;
                e_idx = i;
                e_spr = (spring_en[i] && xn + 32 > px + 55) ? 1 : 0;
                vn = e_spr ? -18 : -12;
                mcd = 1;
                e_pulse = 1;
            end
        end
        mx = xn; my = yn; mv = vn;
    endtask

    initial forever begin
        @(posedge Clk);
        model_step();
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    initial forever begin
        @(negedge Clk);
        if (chk_en) begin
            chk("x", int'(doodle_x), mx);
            chk("y", int'(doodle_y), my);
            chk("v", int'($signed(y_speed)), mv);
            chk("health", int'(health), mh);
            chk("dead", int'(dead), (mst == 2) ? 1 : 0);
            chk("land_pulse", int'(land_pulse), e_pulse);
            chk("land_idx", int'(land_idx), e_idx);
            chk("land_spring", int'(land_spring), e_spr);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
    endtask

    initial begin
        int px, py, guard;
        frame_tick = 1'b1;
        do_reset();
        chk_en = 1'b1;
        chk("reset_x", int'(doodle_x), 304);
        chk("reset_v", int'($signed(y_speed)), -6);
        chk("reset_health", int'(health), 10);

        // Free flight from reset: speed climbs by one per frame.
        tick(1);
        chk("t1_y", int'(doodle_y), 314); chk("t1_v", int'($signed(y_speed)), -5);
        tick(1);
        chk("t2_y", int'(doodle_y), 309); chk("t2_v", int'($signed(y_speed)), -4);
        tick(1);
        chk("t3_y", int'(doodle_y), 305); chk("t3_v", int'($signed(y_speed)), -3);
        chk("t3_x", int'(doodle_x), 304);

        // Jump and cooldown.
        do_reset();
        keycode = 8'h2C;
        tick(1);
        chk("jump_v", int'($signed(y_speed)), -5); chk("jump_y", int'(doodle_y), 314);
        tick(17);
        chk("cd_v", int'($signed(y_speed)), 4); chk("cd_y", int'(doodle_y), 337);
        tick(1);
        chk("cd_last_v", int'($signed(y_speed)), 4);
        tick(1);
        chk("rejump_v", int'($signed(y_speed)), -5); chk("rejump_y", int'(doodle_y), 345);

        // Continuous floor of platforms; walk left across the wrap.
        keycode = 8'h04;
        for (int i = 0; i < 8; i++) begin
            plat_x[i] = 10'(140 + 60 * i);
            plat_y[i] = 10'd400;
        end
        plat_valid = 8'b0011_1111;
        do_reset();
        tick(54);
        chk("left_x", int'(doodle_x), 142);
        tick(1);
        chk("wrap_x", int'(doodle_x), 467);
        run = 1'b0;
        tick(5);
        chk("freeze_x", int'(doodle_x), 467);
        run = 1'b1;
        spring_en = 8'hFF;
        keycode = 8'h07;
        tick(120);

        // Fall-out, respawn and death.
        plat_valid = '0;
        keycode = 8'h00;
        do_reset();
        guard = 0;
        while (mh == 10 && guard < 300) begin tick(1); guard++; end
        chk("fall_health", int'(health), 9);
        tick(1);
        chk("respawn_x", int'(doodle_x), 304);
        chk("respawn_y", int'(doodle_y), 11);
        chk("respawn_v", int'($signed(y_speed)), 0);
        guard = 0;
        while (mst != 2 && guard < 3000) begin tick(1); guard++; end
        chk("dead_reached", (guard < 3000) ? 1 : 0, 1);
        chk("dead_flag", int'(dead), 1);
        chk("dead_health", int'(health), 0);
        tick(10);
        chk("dead_x", int'(doodle_x), 304);
        chk("dead_hold", int'(dead), 1);

        // Randomised play with platforms scattered around the sprite.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            frame_tick = ($urandom_range(0, 1) == 1);
            run = ($urandom_range(0, 9) != 0);
            Reset = ($urandom_range(0, 399) == 0);
            case ($urandom_range(0, 4))
                0: keycode = 8'h00;
                1: keycode = 8'h04;
                2: keycode = 8'h07;
                3: keycode = 8'h2C;
                default: keycode = 8'($urandom_range(0, 255));
            endcase
            for (int i = 0; i < 8; i++) begin
                px = mx + $urandom_range(0, 100) - 65;
                if (px < 0) px = 0;
                py = my + 32 + $urandom_range(0, 6);
                if (py > 1023) py = 1023;
                plat_x[i] = 10'(px);
                plat_y[i] = 10'(py);
            end
            plat_valid = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            spring_en  = 8'($urandom_range(0, 255));
            tick(1);
        end
        Reset = 1'b0;
        tick(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/doodle_physics.md
Name: doodle_physics

Overview:
- Parametrised successor to the single-player Doodle motion block: per-frame horizontal/vertical kinematics with gravity, N-platform landing detection, spring platforms, jump cooldown, fall-out respawn and health tracking.
- Sits between the keyboard keycode path, the platform generator and the sprite renderer / game-state controller.
- Adds what the previous block lacked: platform valid masks, per-platform spring enable, an explicit state machine, health/death, and landing event outputs.

Parameters:
- N_PLAT, 8, number of platform slots checked per frame
- PLAT_W, 60, platform width in pixels
- SPRING_W, 5, spring zone width at the right end of a platform
- SIZE, 32, Doodle sprite width and height
- X_MIN, 140, left playfield edge
- X_MAX, 499, right playfield edge
- Y_TOP, 11, minimum Doodle Y (clamp)
- Y_MAX, 478, bottom limit; fall-out occurs when Y > Y_MAX-SIZE
- X_STEP, 3, horizontal speed magnitude
- GRAVITY, 1, speed increment per frame
- V_TERM, 4, terminal downward speed
- V_JUMP, -6, space-key jump speed
- V_BOUNCE, -12, platform bounce speed
- V_SPRING, -18, spring bounce speed
- JUMP_CD, 18, frames of jump cooldown
- HEALTH_INIT, 10, lives at reset
- START_X, 304, spawn X
- START_Y, 320, spawn Y

Ports:
- Clk  in  1  50 MHz system clock
- Reset  in  1  synchronous, active-high
- frame_tick  in  1  one-Clk pulse per video frame
- run  in  1  1 = game running; 0 = freeze all state
- keycode  in  8  0x04 left, 0x07 right, 0x2C jump
- plat_x  in  N_PLAT x 10  platform left X
- plat_y  in  N_PLAT x 10  platform top Y
- plat_valid  in  N_PLAT  slot occupied
- spring_en  in  N_PLAT  slot carries a spring
- doodle_x  out  10  sprite left X
- doodle_y  out  10  sprite top Y
- y_speed  out  8  signed vertical speed
- health  out  4  remaining lives
- land_pulse  out  1  one-cycle pulse on a landing
- land_idx  out  log2(N_PLAT)  slot landed on
- land_spring  out  1  the landing used a spring
- dead  out  1  health exhausted

Behaviour:
- Clock and reset: clock Clk; reset Reset, synchronous, active-high.
- Reset values:
  - doodle_x=START_X, doodle_y=START_Y, y_speed=V_JUMP, health=HEALTH_INIT
  - land_pulse=0, land_idx=0, land_spring=0, dead=0
  - cooldown=0, state=RUN
- States:
  - RUN: normal play.
  - RESPAWN: one frame; places Doodle at X=START_X, Y=Y_TOP, y_speed=0.
  - DEAD: dead=1; position and speed frozen; left only by Reset.
- Update timing: state updates only on Clk edges where frame_tick=1 and run=1. Registered outputs change on the next edge (1-cycle latency). With run=0 nothing changes and no land_pulse is issued.
- Horizontal motion:
  - Left key gives vx=-X_STEP; right key gives vx=+X_STEP; any other key gives vx=0.
  - x_new = x + vx.
  - If x_new > X_MAX-SIZE, wrap to X_MIN. If x_new < X_MIN, wrap to X_MAX-SIZE.
  - Compute in 11-bit signed to avoid unsigned underflow.
- Jump key: if cooldown==0 then v = V_JUMP and cooldown = JUMP_CD. Otherwise cooldown decrements to a floor of 0, once per frame.
- Gravity: if v < V_TERM then v += GRAVITY, applied after the jump override. y_new = y + old v, computed in 12-bit signed and clamped below at Y_TOP.
- Landing check, per slot i with plat_valid[i]=1 and v > 0:
  - x_new < plat_x+PLAT_W
  - x_new+SIZE > plat_x
  - y+SIZE <= plat_y
  - y+SIZE+v >= plat_y
- On landing:
  - The lowest matching index wins.
  - If spring_en[i]=1 and x_new+SIZE > plat_x+PLAT_W-SPRING_W, then v = V_SPRING and land_spring=1. Otherwise v = V_BOUNCE.
  - cooldown = 1, land_pulse = 1 for one Clk, land_idx = i.
- Fall-out: if y > Y_MAX-SIZE at the frame tick, decrement health and skip the landing check.
  - If health becomes 0, go to DEAD.
  - Otherwise go to RESPAWN, then back to RUN on the next frame.
- Simultaneous events: fall-out beats landing, and landing beats the jump key. Reset beats everything.
- Health saturates at 0 and never wraps.

Decomposition:
- Package doodle_pkg:
  - keycode constants KEY_LEFT, KEY_RIGHT, KEY_JUMP
  - enum phys_state_t {RUN, RESPAWN, DEAD}
  - coord_t (10-bit) and speed_t (signed 8-bit) typedefs
- Sub-module plat_hit_detect: combinational N_PLAT-way overlap test with priority encoder. Outputs hit, idx, spring.

Test Plan:
- Reset, then 3 ticks with no key -> y_speed goes -6 → -5 → -4 → -3; y decreases 6, then 5, then 4; x stays 304.
- Right key held with x=464 -> x_new=467 > 467 is false so x=467; next tick x=470 > 467, so x wraps to 140.
- Platform 3 at (300,400), valid, v=4, y=366 -> land_pulse for 1 cycle, land_idx=3, y_speed=-12. Repeat with spring_en[3]=1 and x=330 -> y_speed=-18, land_spring=1.
- Slots 2 and 5 both matching -> land_idx=2. plat_valid[2]=0 -> land_idx=5. v<=0 -> no landing.
- y=447 at a tick with health=2 -> health=1, then respawn at (304,11) with v=0. Repeat a fall-out with health=1 -> health=0, dead=1, outputs frozen across 10 ticks until Reset.
- Jump key pressed at cooldown 0 -> y_speed=-5 after gravity; key held for 17 more ticks -> no re-jump. run=0 mid-flight -> all outputs frozen for 5 ticks.
